// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch sequencer
`timescale 1ns/1ps
package fetch_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } fetch_state_t;

  localparam int          INST_BYTES = 4;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  // Branch targets are always word aligned; the low two bits are dropped
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer with redirect handling; FETCH_TIMEOUT_EN adds an ack timeout
`timescale 1ns/1ps
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("fetch_ctrl: TIMEOUT must be at least 1");
  end

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_q, pend_d;
  logic         drop_q, drop_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         err_q, err_d;
  logic         timeout_hit;
  logic [31:0]  target;

  assign target = align_pc(redirect_pc);

`ifdef FETCH_TIMEOUT_EN
  localparam int              CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   T_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] wait_cnt;

  // Count consecutive FETCH cycles with no ack; any ack or leaving FETCH restarts it
  always_ff @(posedge clk) begin
    if (rst || state_q != FETCH || imem_ack) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state_q == FETCH) && !imem_ack && (wait_cnt == T_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // State and datapath registers; reset abandons any outstanding request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pend_q    <= '0;
      drop_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      drop_q    <= drop_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      err_q     <= err_d;
    end
  end

  // Next-state and PC selection, including redirects that land mid-fetch
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          pc_d = target;
        end else if (!halt) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          if (drop_q) begin
            // Returned word belongs to a stale path; refetch from the newest target
            pc_d   = redirect_valid ? target : pend_q;
            drop_d = 1'b0;
          end else if (redirect_valid) begin
            pc_d = target;
          end else begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
            state_d   = VALID;
          end
        end else begin
          // Request stays up; remember where to go once it returns
          if (redirect_valid) begin
            pend_d = target;
            drop_d = 1'b1;
          end
          if (timeout_hit) begin
            err_d   = 1'b1;
            drop_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      VALID: begin
        if (redirect_valid || inst_ready) begin
          pc_d    = redirect_valid ? target : pc_q + 32'(INST_BYTES);
          state_d = halt ? IDLE : FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == VALID);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign fetch_err  = err_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request/ack handshake. It delivers fetched instructions to decode with a valid/ready handshake. It applies branch/jump redirects from execute, including redirects that arrive while a fetch is still outstanding. It sits between the PC/next-PC logic and decode, and replaces the free-running PC register in multi-cycle-memory configurations.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 16, max cycles to wait for imem_ack. Used only with FETCH_TIMEOUT_EN.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, synchronous, active-high.
halt  input  1  stop issuing new fetches; any outstanding fetch completes.
imem_req  output  1  fetch request; held high until imem_ack.
imem_addr  output  32  fetch address; stable while imem_req=1.
imem_ack  input  1  one-cycle pulse: imem_rdata valid this cycle.
imem_rdata  input  32  fetched instruction word.
inst_valid  output  1  inst/inst_pc valid to decode.
inst_ready  input  1  decode accepts the instruction.
inst  output  32  instruction word.
inst_pc  output  32  address of inst.
redirect_valid  input  1  branch/jump taken this cycle.
redirect_pc  input  32  target; bits [1:0] ignored (forced 00).
fetch_err  output  1  timeout flag, sticky. Tied 0 when FETCH_TIMEOUT_EN is undefined.

Behaviour:
- Registers: pc (current fetch address), pend_pc, drop flag, inst/inst_pc registers, 2-bit state.
- Reset values: state=IDLE, pc=RESET_PC, drop=0, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fetch_err=0.
- Reset has priority over all other inputs. Reset mid-fetch abandons the request: imem_req=0 next cycle, and a late ack is ignored because state=IDLE.
- imem_addr = pc at all times. imem_req = (state==FETCH).
- IDLE:
  - halt=0 -> FETCH next cycle.
  - redirect_valid -> pc<=redirect_pc, stay IDLE.
- FETCH:
  - Without ack, redirect_valid -> pend_pc<=redirect_pc, drop<=1. The request is not withdrawn. The latest redirect wins.
  - ack with drop=1 -> discard rdata; pc<=pend_pc (or redirect_pc if redirect_valid this cycle); drop<=0; stay FETCH. A new request goes out next cycle.
  - ack with drop=0 and redirect_valid -> discard rdata; pc<=redirect_pc; stay FETCH.
  - ack with drop=0 and no redirect -> inst<=imem_rdata, inst_pc<=pc, go VALID.
  - Minimum latency is 1 cycle: ack may arrive in the first cycle req is high.
- VALID (inst_valid=1; inst/inst_pc stable until accepted):
  - redirect_valid -> inst_valid<=0, pc<=redirect_pc. Redirect beats inst_ready; the instruction is squashed.
  - Otherwise, when inst_ready=1: pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), inst_valid<=0.
  - Exit (either case): halt=1 -> IDLE, else -> FETCH.
- Steady-state throughput with ready=1 and 1-cycle ack: one instruction per 2 cycles.
- halt is sampled only on IDLE->FETCH and VALID exit.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A $clog2(TIMEOUT+1)-bit counter clears on entry to FETCH and counts each FETCH cycle without ack.
  - When it reaches TIMEOUT: fetch_err<=1 (sticky until rst), drop<=0, state->IDLE, imem_req drops.
- Undefined: no counter; fetch_err tied 0; FETCH waits indefinitely.

Decomposition:
- Package fetch_pkg holds:
  - state encoding: IDLE=2'd0, FETCH=2'd1, VALID=2'd2;
  - INST_BYTES=4;
  - NOP=32'h0000_0013.
- No sub-module is needed; the timeout counter is inline under the macro.

Test Plan:
- Reset then halt=0, ack 1 cycle after each req, ready=1 -> imem_addr sequence 0,4,8,C; inst_pc matches; one inst_valid every 2 cycles.
- Ack delayed 3 cycles with redirect_pc=32'h100 in the 2nd wait cycle -> returned word discarded, inst_valid stays 0, next imem_addr=32'h100.
- Redirects 0x200 then 0x300 during one outstanding fetch -> next fetch address 0x300.
- inst_valid held with ready=0 for 4 cycles -> inst/inst_pc stable. Then ready=1 and redirect 0x40 in the same cycle -> squashed, next addr 0x40.
- RESET_PC=32'hFFFF_FFFC -> first fetch FFFF_FFFC, second fetch 0.
- With FETCH_TIMEOUT_EN and TIMEOUT=16, no ack -> fetch_err=1 after 16 req cycles, imem_req=0, fetch_err stays 1 until rst.
